// File: rtl/adc_pair_unpacker_if.sv
// Purpose: bundles the packed-word input stream and the unpacked-sample output
//          stream of adc_pair_unpacker into one Avalon-ST style interface.
// Ports:   asi_in0_* carries 32-bit packed sample pairs (valid/ready).
//          aso_out0_* carries 12-bit samples with channel and SOP/EOP (valid/ready).
// Modports: slave = the unpacker's view; master = the environment driving it.
interface adc_pair_unpacker_if;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_ready;
  logic [11:0] aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_ready;
  logic [4:0]  aso_out0_channel;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;

  modport slave (
    input  asi_in0_data, asi_in0_valid, aso_out0_ready,
    output asi_in0_ready, aso_out0_data, aso_out0_valid, aso_out0_channel,
           aso_out0_startofpacket, aso_out0_endofpacket
  );

  modport master (
    output asi_in0_data, asi_in0_valid, aso_out0_ready,
    input  asi_in0_ready, aso_out0_data, aso_out0_valid, aso_out0_channel,
           aso_out0_startofpacket, aso_out0_endofpacket
  );
endinterface

// File: rtl/adc_pair_unpacker.sv
// Purpose: unpacks 32-bit words {4'b0, s1[11:0], 4'b0, s0[11:0]} into 2-beat packets.
// Latency: word accepted into an empty FIFO at edge k -> SOP beat valid after edge k+1.
// Backpressure: FIFO_DEPTH-entry word FIFO; asi_in0_ready low only when the FIFO is full.
// Ports:   csi_clk, rsi_reset_n (synchronous, active-low), avst (slave modport of
//          adc_pair_unpacker_if), coe_pad_err (sticky padding error).
// Option:  define ADC_UNPACK_PADCHK_EN to enable the padding-bit check; otherwise
//          coe_pad_err is tied low.
module adc_pair_unpacker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  CH_FIRST   = 5'd0,
  parameter logic [4:0]  CH_SECOND  = 5'd1
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset_n,
  adc_pair_unpacker_if.slave   avst,
  output logic                 coe_pad_err
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, fifo_empty;

  // Ready depends only on registered FIFO occupancy, so a pop in the full
  // cycle frees a slot that becomes visible one cycle later.
  assign avst.asi_in0_ready = (count_q != FULL_CNT);
  assign push               = avst.asi_in0_valid && avst.asi_in0_ready;
  assign fifo_empty         = (count_q == '0);

  always_comb begin
    state_d                     = state_q;
    hold_d                      = hold_q;
    pop                         = 1'b0;
    avst.aso_out0_valid         = 1'b0;
    avst.aso_out0_data          = '0;
    avst.aso_out0_channel       = '0;
    avst.aso_out0_startofpacket = 1'b0;
    avst.aso_out0_endofpacket   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        avst.aso_out0_valid         = 1'b1;
        avst.aso_out0_data          = hold_q[11:0];
        avst.aso_out0_channel       = CH_FIRST;
        avst.aso_out0_startofpacket = 1'b1;
        if (avst.aso_out0_ready) state_d = BEAT1;
      end
      BEAT1: begin
        avst.aso_out0_valid         = 1'b1;
        avst.aso_out0_data          = hold_q[27:16];
        avst.aso_out0_channel       = CH_SECOND;
        avst.aso_out0_endofpacket   = 1'b1;
        if (avst.aso_out0_ready) begin
          // Reload straight into BEAT0 so back-to-back packets have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            state_d = BEAT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge csi_clk) begin
    if (push) mem_q[wr_ptr_q] <= avst.asi_in0_data;
  end

  // Padding bits travel with the word but never reach the output.
  logic pad_unused;
  assign pad_unused = ^{hold_q[31:28], hold_q[15:12]};

`ifdef ADC_UNPACK_PADCHK_EN
  logic pad_err_q;
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      pad_err_q <= 1'b0;
    end else if (push && ((|avst.asi_in0_data[31:28]) || (|avst.asi_in0_data[15:12]))) begin
      pad_err_q <= 1'b1;
    end
  end
  assign coe_pad_err = pad_err_q;
`else
  assign coe_pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_pair_unpacker.sv
// Purpose: scoreboard bench for adc_pair_unpacker; expected beats are queued at
//          word acceptance and checked by an independent output monitor.
// Latency/backpressure: exercises first-beat latency, full FIFO, stalls and reset.
module tb_adc_pair_unpacker;

  localparam logic [4:0] CH0 = 5'd0;
  localparam logic [4:0] CH1 = 5'd1;

  logic csi_clk;
  logic rst_n;
  logic coe_pad_err;
  int   rdy_mode;        // 0 = sink stalls, 1 = sink always ready, 2 = random
  int   n_cmp;
  int   n_bad;
  int   beats_seen;
  logic [18:0] exp_q[$]; // {data, channel, sop, eop}
  logic        prev_stall;
  logic [18:0] prev_beat;

  adc_pair_unpacker_if bus ();

  adc_pair_unpacker #(
    .FIFO_DEPTH(4),
    .CH_FIRST  (CH0),
    .CH_SECOND (CH1)
  ) dut (
    .csi_clk    (csi_clk),
    .rsi_reset_n(rst_n),
    .avst       (bus),
    .coe_pad_err(coe_pad_err)
  );

  initial begin
    csi_clk = 1'b0;
    forever #5 csi_clk = ~csi_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sink ready is driven 2 time units after each rising edge.
  always @(posedge csi_clk) begin
    #2;
    case (rdy_mode)
      0:       bus.aso_out0_ready = 1'b0;
      1:       bus.aso_out0_ready = 1'b1;
      default: bus.aso_out0_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: a beat transfers at the next edge when valid && ready at the negedge.
  always @(negedge csi_clk) begin
    logic [18:0] cur;
    cur = {bus.aso_out0_data, bus.aso_out0_channel,
           bus.aso_out0_startofpacket, bus.aso_out0_endofpacket};
    if (rst_n === 1'b1) begin
      if (prev_stall) chk("stall_stable", 32'(cur), 32'(prev_beat));
      if (bus.aso_out0_valid === 1'b1 && bus.aso_out0_ready === 1'b1) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat at %0t", cur, $time);
        end else begin
          chk("beat", 32'(cur), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = (bus.aso_out0_valid === 1'b1) && (bus.aso_out0_ready !== 1'b1);
      prev_beat  = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offers one word; called and returns 1 time unit after a rising edge.
  task automatic push(input logic [31:0] w);
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    bus.asi_in0_valid = 1'b1;
    bus.asi_in0_data  = w;
    while (!acc && t < 200) begin
      @(negedge csi_clk);
      acc = (bus.asi_in0_ready === 1'b1);
      if (acc) begin
        exp_q.push_back({w[11:0], CH0, 1'b1, 1'b0});
        exp_q.push_back({w[27:16], CH1, 1'b0, 1'b1});
      end
      @(posedge csi_clk);
      #1;
      t++;
    end
    bus.asi_in0_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge csi_clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    int          cyc;
    int          snap;
    logic        pad_exp;
    n_cmp = 0;
    n_bad = 0;
    beats_seen = 0;
    prev_stall = 1'b0;
    prev_beat  = '0;
    rdy_mode   = 1;
    rst_n      = 1'b0;
    bus.asi_in0_valid = 1'b0;
    bus.asi_in0_data  = '0;

`ifdef ADC_UNPACK_PADCHK_EN
    pad_exp = 1'b1;
`else
    pad_exp = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge csi_clk);
    #1;
    chk("rst_valid",  32'(bus.aso_out0_valid), 0);
    chk("rst_data",   32'(bus.aso_out0_data), 0);
    chk("rst_ch",     32'(bus.aso_out0_channel), 0);
    chk("rst_sop",    32'(bus.aso_out0_startofpacket), 0);
    chk("rst_eop",    32'(bus.aso_out0_endofpacket), 0);
    chk("rst_in_rdy", 32'(bus.asi_in0_ready), 1);
    chk("rst_pad",    32'(coe_pad_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge csi_clk);
    #1;

    // Single word: latency and return to IDLE when FIFO runs dry
    push(32'h0ABC_0123);
    chk("lat_k", 32'(bus.aso_out0_valid), 0);
    @(posedge csi_clk); #1;
    chk("lat_k1_valid", 32'(bus.aso_out0_valid), 1);
    chk("lat_k1_sop",   32'(bus.aso_out0_startofpacket), 1);
    @(posedge csi_clk); #1;
    chk("beat1_eop", 32'(bus.aso_out0_endofpacket), 1);
    @(posedge csi_clk); #1;
    chk("idle_gap", 32'(bus.aso_out0_valid), 0);
    wait_drain(20);

    // Fill: one word goes to the hold register, four fill the FIFO
    rdy_mode = 0;
    repeat (2) @(posedge csi_clk);
    #1;
    push(32'h0111_0222);
    push(32'h0333_0444);
    push(32'h0555_0666);
    push(32'h0777_0888);
    chk("in_rdy_3q", 32'(bus.asi_in0_ready), 1);
    push(32'h0999_0AAA);
    chk("in_rdy_full", 32'(bus.asi_in0_ready), 0);
    rdy_mode = 1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge csi_clk); #1;
      cyc++;
      if (cyc == 1) chk("full_no_pop", 32'(bus.asi_in0_ready), 0);
      if (cyc == 2) chk("full_popped", 32'(bus.asi_in0_ready), 1);
    end
    chk("drain_cycles", cyc, 10);

    // Reset during BEAT1 with three words queued
    rdy_mode = 0;
    repeat (2) @(posedge csi_clk);
    #1;
    push(32'h0ABC_0DEF);
    push(32'h0123_0456);
    push(32'h0789_0FED);
    push(32'h0CBA_0987);
    rdy_mode = 1;
    cyc = 0;
    while (bus.aso_out0_endofpacket !== 1'b1 && cyc < 20) begin
      @(posedge csi_clk); #1;
      cyc++;
    end
    chk("reach_beat1", 32'(bus.aso_out0_endofpacket), 1);
    rst_n = 1'b0;
    @(posedge csi_clk); #1;
    chk("mid_rst_valid",  32'(bus.aso_out0_valid), 0);
    chk("mid_rst_in_rdy", 32'(bus.asi_in0_ready), 1);
    exp_q.delete();
    rst_n = 1'b1;
    snap = beats_seen;
    repeat (10) @(posedge csi_clk);
    #1;
    chk("no_beats_after_rst", beats_seen - snap, 0);

    // Padding check (sticky; only with the check compiled in)
    push(32'h1000_0000);
    chk("pad_hi", 32'(coe_pad_err), 32'(pad_exp));
    push(32'h0000_0001);
    chk("pad_sticky", 32'(coe_pad_err), 32'(pad_exp));
    wait_drain(20);
    do_reset();
    chk("pad_cleared", 32'(coe_pad_err), 0);
    push(32'h0000_F000);
    chk("pad_lo", 32'(coe_pad_err), 32'(pad_exp));
    wait_drain(20);
    do_reset();

    // Random sink backpressure over many clean words
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom;
      w = {4'h0, r[27:16], 4'h0, r[11:0]};
      push(w);
    end
    wait_drain(6000);
    rdy_mode = 1;
    repeat (4) @(posedge csi_clk);
    #1;
    chk("final_idle", 32'(bus.aso_out0_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
